// File: rtl/frac_arith_pkg.sv
// frac_arith_pkg: shared widths, state type and latency helper for the fractional multiplier.
// FRAC_MUL_RADIX4_EN selects the two-bits-per-cycle build.
package frac_arith_pkg;
    localparam int NI_DEF = 32;
    localparam int NO_DEF = 40;
`ifdef FRAC_MUL_RADIX4_EN
    localparam int MUL_SH = 2;
`else
    localparam int MUL_SH = 1;
`endif
    typedef enum logic {IDLE, RUN} state_t;
    function automatic int mul_latency(input int ni);
        return ni / MUL_SH;
    endfunction
endpackage

// File: rtl/frac_multiplier_if.sv
// frac_multiplier_if: request/operand/result bundle between a requester and frac_multiplier.
interface frac_multiplier_if import frac_arith_pkg::*; #(
    parameter int NI = NI_DEF,
    parameter int NO = NO_DEF
);
    logic          start;
    logic [NO:0]   q;
    logic [NI-1:0] b;
    logic          busy;
    logic          done;
    logic [NO+NI:0] p;
    modport master (output start, q, b, input busy, done, p);
    modport slave (input start, q, b, output busy, done, p);
endinterface

// File: rtl/frac_mul_step.sv
// frac_mul_step: one add-and-shift iteration; b and the low product bits share one shift field.
// FRAC_MUL_RADIX4_EN consumes two bits of b per step using a precomputed 3q.
module frac_mul_step import frac_arith_pkg::*; #(
    parameter int NI = NI_DEF,
    parameter int NO = NO_DEF
) (
    input  logic [NO:0]   i_acc,
    input  logic [NI-1:0] i_bl,
    input  logic [NO:0]   i_q,
`ifdef FRAC_MUL_RADIX4_EN
    input  logic [NO+2:0] i_q3,
`endif
    output logic [NO:0]   o_acc,
    output logic [NI-1:0] o_bl
);
    localparam int AW = NO + 1 + MUL_SH;
    logic [AW-1:0] w_add;
    logic [AW-1:0] w_sum;
`ifdef FRAC_MUL_RADIX4_EN
    assign w_add = (i_bl[1:0] == 2'd3) ? i_q3 :
                   i_bl[1] ? AW'({i_q, 1'b0}) :
                   i_bl[0] ? AW'(i_q) : '0;
`else
    assign w_add = i_bl[0] ? AW'(i_q) : '0;
`endif
    assign w_sum = AW'(i_acc) + w_add;
    // shifted-out sum bits enter the top of the field as consumed b bits leave the bottom
    assign {o_acc, o_bl} = {w_sum, i_bl[NI-1:MUL_SH]};
endmodule

// File: rtl/frac_multiplier.sv
// frac_multiplier: sequential shift-add p = q * b, exact 1.(no+ni) product.
// Define FRAC_MUL_RADIX4_EN for radix-4 (latency ni/2); default radix-2 (latency ni).
module frac_multiplier import frac_arith_pkg::*; #(
    parameter int NI = NI_DEF,
    parameter int NO = NO_DEF
) (
    input logic          clk,
    input logic          rst,
    frac_multiplier_if.slave bus
);
    localparam int CW = $clog2(NI) + 1;
    localparam logic [CW-1:0] LAST = CW'(mul_latency(NI) - 1);
`ifdef FRAC_MUL_RADIX4_EN
    if (NI % 2 != 0) begin : g_ni_odd
        $error("frac_multiplier: radix-4 build needs an even NI");
    end
    logic [NO+2:0] r_q3;
`endif
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [NO:0]    r_q;
    logic [NO:0]    r_acc;
    logic [NI-1:0]  r_bl;
    logic           r_done;
    logic [NO+NI:0] r_p;
    logic [NO:0]    w_acc;
    logic [NI-1:0]  w_bl;
    frac_mul_step #(.NI(NI), .NO(NO)) u_step (
        .i_acc (r_acc),
        .i_bl  (r_bl),
        .i_q   (r_q),
`ifdef FRAC_MUL_RADIX4_EN
        .i_q3  (r_q3),
`endif
        .o_acc (w_acc),
        .o_bl  (w_bl)
    );
    assign bus.busy = r_state == RUN;
    assign bus.done = r_done;
    assign bus.p    = r_p;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_bl    <= '0;
            r_done  <= 1'b0;
            r_p     <= '0;
`ifdef FRAC_MUL_RADIX4_EN
            r_q3    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                    r_q     <= bus.q;
                    r_acc   <= '0;
                    r_bl    <= bus.b;
`ifdef FRAC_MUL_RADIX4_EN
                    r_q3    <= {2'b0, bus.q} + {1'b0, bus.q, 1'b0};
`endif
                end
            end else begin
                r_acc <= w_acc;
                r_bl  <= w_bl;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                    r_p     <= {w_acc, w_bl};
                end
            end
        end
    end
endmodule

// File: tb/tb_frac_multiplier.sv
// tb_frac_multiplier: directed and randomized checks of frac_multiplier against an arithmetic model.
module tb_frac_multiplier;
    localparam int NI = 32;
    localparam int NO = 40;
    localparam int PW = NO + NI + 1;
`ifdef FRAC_MUL_RADIX4_EN
    localparam int L = NI / 2;
`else
    localparam int L = NI;
`endif
    localparam logic [NO:0] Q_ONE  = 41'h100_0000_0000;
    localparam logic [NO:0] Q_ONES = 41'h1FF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;

    frac_multiplier_if #(.NI(NI), .NO(NO)) bus();
    frac_multiplier #(.NI(NI), .NO(NO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [PW-1:0] model(input logic [NO:0] q, input logic [NI-1:0] b);
        return PW'(q) * PW'(b);
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.start = 1'b0;
        bus.q = (NO+1)'({$urandom, $urandom});
        bus.b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < L + 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) return;
        end
        check("timeout", 128'(lat), 128'(L));
    endtask

    task automatic run_op(input string tag, input logic [NO:0] q, input logic [NI-1:0] b);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.q = q;
        bus.b = b;
        @(posedge clk);
        #1;
        scramble();
        check({tag, ".busy"}, 128'(bus.busy), 128'(1));
        wait_done(lat);
        check({tag, ".lat"}, 128'(lat), 128'(L));
        check({tag, ".p"}, 128'(bus.p), 128'(model(q, b)));
        check({tag, ".idle"}, 128'(bus.busy), 128'(0));
    endtask

    initial begin
        int lat;
        int lat2;
        logic seen;
        logic [NO:0] qa;
        logic [NI-1:0] ba;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 128'(bus.busy), 128'(0));
        check("rst.done", 128'(bus.done), 128'(0));
        check("rst.p", 128'(bus.p), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op("one", Q_ONE, 32'h8000_0000);
        check("one.bit", 128'(bus.p), 128'(1) << 71);
        run_op("ones", Q_ONES, 32'hFFFF_FFFF);
        check("ones.exact", 128'(bus.p), 128'h1FF_FFFF_FFFF * 128'hFFFF_FFFF);
        run_op("bzero", 41'h1_2345_6789_AB, 32'h0);
        run_op("qzero", 41'h0, $urandom);

        // start while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.q = Q_ONE;
        bus.b = 32'hC000_0000;
        @(posedge clk);
        #1;
        scramble();
        lat = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 4) begin
                bus.start = 1'b1;
                bus.q = '0;
                bus.b = '0;
            end else scramble();
        end
        check("ign.busy", 128'(bus.busy), 128'(1));
        wait_done(lat2);
        check("ign.lat", 128'(lat + lat2), 128'(L));
        check("ign.p", 128'(bus.p), 128'(3) << 70);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.q = Q_ONES;
        bus.b = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        scramble();
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst.busy", 128'(bus.busy), 128'(0));
        check("arst.done", 128'(bus.done), 128'(0));
        check("arst.p", 128'(bus.p), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (L + 5) begin
            @(posedge clk);
            #1;
            seen |= bus.done;
        end
        check("arst.nodone", 128'(seen), 128'(0));
        run_op("postrst", Q_ONES, 32'h1234_5678);

        // back-to-back: new start in the done cycle
        qa = (NO+1)'({$urandom, $urandom});
        ba = $urandom;
        run_op("b2b.a", qa, ba);
        bus.start = 1'b1;
        bus.q = Q_ONE;
        bus.b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        scramble();
        check("b2b.done", 128'(bus.done), 128'(0));
        check("b2b.busy", 128'(bus.busy), 128'(1));
        check("b2b.hold", 128'(bus.p), 128'(model(qa, ba)));
        wait_done(lat);
        check("b2b.lat", 128'(lat), 128'(L));
        check("b2b.p", 128'(bus.p), 128'hFFFF_FFFF << 40);

        // random: divider round-trip contract plus unconstrained operands
        for (int i = 0; i < 1500; i++) begin
            logic [NI-1:0] a_i;
            logic [NI-1:0] b_i;
            logic [NO:0] q_i;
            logic [127:0] num;
            logic [127:0] prod;
            if (i % 4 == 0) begin
                run_op("raw", (NO+1)'({$urandom, $urandom}), $urandom);
            end else begin
                a_i = $urandom | 32'h8000_0000;
                b_i = $urandom | 32'h8000_0000;
                num = 128'(a_i) << NO;
                q_i = (NO+1)'(num / 128'(b_i));
                run_op("rnd", q_i, b_i);
                prod = 128'(bus.p);
                check("contract", 128'(prod <= num && num < prod + 128'(b_i)), 128'(1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
